// File: rtl/pr_bus_arbiter_pkg.sv
// Shared types and encodings for the two-master device-bus arbiter.
package pr_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2,
    ERR  = 2'd3
  } state_e;

  localparam logic M0 = 1'b0;
  localparam logic M1 = 1'b1;

  // Transfer captured at grant time and replayed on the device bus.
  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wd;
    logic        we;
    logic [3:0]  be;
  } xfer_t;

  // Device bus is word addressed; byte offset is carried by the byte enables.
  function automatic logic [31:0] word_align(input logic [31:0] a);
    return a & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/pr_bus_arbiter_if.sv
// Master-side and device-side signals of the arbiter, bundled.
// slave: arbiter view. master: environment view (requesters + device).
interface pr_bus_arbiter_if;
  import pr_bus_arbiter_pkg::*;

  logic        m0_req;
  logic [31:0] m0_addr;
  logic [31:0] m0_wd;
  logic        m0_we;
  logic [3:0]  m0_be;
  logic [31:0] m0_rd;
  logic        m0_ack;
  logic        m0_err;

  logic        m1_req;
  logic [31:0] m1_addr;
  logic [31:0] m1_wd;
  logic        m1_we;
  logic [3:0]  m1_be;
  logic [31:0] m1_rd;
  logic        m1_ack;
  logic        m1_err;

  logic        dev_req;
  logic [31:0] dev_addr;
  logic [31:0] dev_wd;
  logic        dev_we;
  logic [3:0]  dev_be;
  logic [31:0] dev_rd;
  logic        dev_ack;

  logic        owner;

  modport slave (
    input  m0_req, m0_addr, m0_wd, m0_we, m0_be,
    output m0_rd, m0_ack, m0_err,
    input  m1_req, m1_addr, m1_wd, m1_we, m1_be,
    output m1_rd, m1_ack, m1_err,
    output dev_req, dev_addr, dev_wd, dev_we, dev_be,
    input  dev_rd, dev_ack,
    output owner
  );

  modport master (
    output m0_req, m0_addr, m0_wd, m0_we, m0_be,
    input  m0_rd, m0_ack, m0_err,
    output m1_req, m1_addr, m1_wd, m1_we, m1_be,
    input  m1_rd, m1_ack, m1_err,
    input  dev_req, dev_addr, dev_wd, dev_we, dev_be,
    output dev_rd, dev_ack,
    input  owner
  );

endinterface

// File: rtl/pr_rr_pick.sv
// Combinational 2-way round-robin select: on contention, the master that
// did not win last time gets the grant.
module pr_rr_pick (
  input  logic req0_i,
  input  logic req1_i,
  input  logic rr_last_i,
  output logic gnt_valid_o,
  output logic gnt_id_o
);
  // Single requester wins outright; both requesting alternates on rr_last.
  always_comb begin
    gnt_valid_o = req0_i | req1_i;
    gnt_id_o    = (req0_i & req1_i) ? ~rr_last_i : req1_i;
  end
endmodule

// File: rtl/pr_bus_arbiter.sv
// Two-master arbiter/sequencer for the processor device bus: grants one
// master, replays its latched transfer on dev_*, waits for dev_ack with a
// timeout and returns a one-cycle ack or err pulse to the owner.
module pr_bus_arbiter
  import pr_bus_arbiter_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 8
) (
  input logic clk,
  input logic reset,
  pr_bus_arbiter_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_e            state_q, state_d;
  logic              owner_q, owner_d;
  logic              rr_q, rr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  xfer_t             xf_q, xf_d;
  logic [31:0]       rd0_q, rd0_d, rd1_q, rd1_d;
  logic              gnt_valid, gnt_id;
  xfer_t             sel;

  pr_rr_pick u_pick (
    .req0_i      (bus.m0_req),
    .req1_i      (bus.m1_req),
    .rr_last_i   (rr_q),
    .gnt_valid_o (gnt_valid),
    .gnt_id_o    (gnt_id)
  );

  // Transfer fields of whichever master the picker selected.
  always_comb begin
    sel.addr = word_align(gnt_id ? bus.m1_addr : bus.m0_addr);
    sel.wd   = gnt_id ? bus.m1_wd : bus.m0_wd;
    sel.we   = gnt_id ? bus.m1_we : bus.m0_we;
    sel.be   = gnt_id ? bus.m1_be : bus.m0_be;
  end

  // Next-state: arbitration, wait counting, read-data capture.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    rr_d    = rr_q;
    cnt_d   = cnt_q;
    xf_d    = xf_q;
    rd0_d   = rd0_q;
    rd1_d   = rd1_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (gnt_valid) begin
          owner_d = gnt_id;
          xf_d    = sel;
          // A write with no byte lanes never touches the device.
          state_d = (sel.we && sel.be == 4'b0000) ? DONE : BUSY;
        end
      end
      BUSY: begin
        cnt_d = cnt_q + CNT_W'(1);
        // dev_ack wins over a timeout landing on the same cycle.
        if (bus.dev_ack) begin
          if (!xf_q.we) begin
            if (owner_q == M1) rd1_d = bus.dev_rd;
            else               rd0_d = bus.dev_rd;
          end
          state_d = DONE;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ERR;
        end
      end
      DONE, ERR: begin
        rr_d    = owner_q;
        cnt_d   = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and latch registers; reset clears latched transfer data.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      owner_q <= M0;
      rr_q    <= M0;
      cnt_q   <= '0;
      xf_q    <= '0;
      rd0_q   <= '0;
      rd1_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      rr_q    <= rr_d;
      cnt_q   <= cnt_d;
      xf_q    <= xf_d;
      rd0_q   <= rd0_d;
      rd1_q   <= rd1_d;
    end
  end

  assign bus.dev_req  = (state_q == BUSY);
  assign bus.dev_addr = xf_q.addr;
  assign bus.dev_wd   = xf_q.wd;
  assign bus.dev_we   = xf_q.we;
  assign bus.dev_be   = xf_q.be;

  assign bus.m0_rd  = rd0_q;
  assign bus.m1_rd  = rd1_q;
  assign bus.m0_ack = (state_q == DONE) && (owner_q == M0);
  assign bus.m1_ack = (state_q == DONE) && (owner_q == M1);
  assign bus.m0_err = (state_q == ERR)  && (owner_q == M0);
  assign bus.m1_err = (state_q == ERR)  && (owner_q == M1);
  assign bus.owner  = owner_q;

endmodule
